// File: rtl/mk8_gpio_pkg.sv
// Shared constants for the Mk8 GPIO edge-interrupt port: register map and bus widths.
package mk8_gpio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd7;

  // Value returned when reading a write-only (set/clear) address.
  localparam logic [BUS_W-1:0] READBACK_WO = 32'h0;

endpackage

// File: rtl/mk8_gpio_debounce.sv
// One-bit input path: metastability synchroniser followed by a debounce counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module mk8_gpio_debounce
  import mk8_gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Counter restarts whenever the synchronised level agrees with the accepted one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (s == stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mk8_gpio_edge_irq.sv
// Avalon-MM GPIO port with debounced inputs, per-bit rise/fall edge capture
// (write-1-to-clear), set/clear output aliases and a maskable level interrupt.
module mk8_gpio_edge_irq
  import mk8_gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] OUT_RESET       = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] stable;
  logic [DATA_WIDTH-1:0] stable_d_q;
  logic [DATA_WIDTH-1:0] irq_mask_q;
  logic [DATA_WIDTH-1:0] edge_cap_q;
  logic [DATA_WIDTH-1:0] rise_en_q;
  logic [DATA_WIDTH-1:0] fall_en_q;

  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] edge_c;
  logic [DATA_WIDTH-1:0] clr_c;
  logic [BUS_W-1:0]      rd_mux_c;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_in
    mk8_gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en_c = chipselect & ~write_n;
  assign wdata_c = writedata[DATA_WIDTH-1:0];
  assign edge_c  = (stable & ~stable_d_q & rise_en_q) | (~stable & stable_d_q & fall_en_q);
  assign clr_c   = (wr_en_c && address == ADDR_EDGE_CAP) ? wdata_c : '0;

  // Register file; a new edge takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port   <= OUT_RESET[DATA_WIDTH-1:0];
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      stable_d_q <= '0;
    end else begin
      stable_d_q <= stable;
      edge_cap_q <= (edge_cap_q & ~clr_c) | edge_c;
      if (wr_en_c) begin
        case (address)
          ADDR_DATA:     out_port   <= wdata_c;
          ADDR_IRQ_MASK: irq_mask_q <= wdata_c;
          ADDR_OUT_SET:  out_port   <= out_port | wdata_c;
          ADDR_OUT_CLR:  out_port   <= out_port & ~wdata_c;
          ADDR_RISE_EN:  rise_en_q  <= wdata_c;
          ADDR_FALL_EN:  fall_en_q  <= wdata_c;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux_c = READBACK_WO;
    case (address)
      ADDR_DATA:     rd_mux_c = BUS_W'(stable);
      ADDR_OUT:      rd_mux_c = BUS_W'(out_port);
      ADDR_IRQ_MASK: rd_mux_c = BUS_W'(irq_mask_q);
      ADDR_EDGE_CAP: rd_mux_c = BUS_W'(edge_cap_q);
      ADDR_RISE_EN:  rd_mux_c = BUS_W'(rise_en_q);
      ADDR_FALL_EN:  rd_mux_c = BUS_W'(fall_en_q);
      default:       rd_mux_c = READBACK_WO;
    endcase
  end

  // Read data is refreshed every cycle, independent of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux_c;
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_mk8_gpio_edge_irq.sv
// Directed bench for mk8_gpio_edge_irq; read expectations are queued at issue and
// checked when readdata returns.
module tb_mk8_gpio_edge_irq;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  mk8_gpio_edge_irq #(
    .DATA_WIDTH      (32),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .OUT_RESET       (32'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, readdata, e);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 32'h0;
    cyc(3);
    check("rst_out_port", out_port, 32'hA5);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    rd(3'd1, 32'hA5, "rst_rd_out");
    rd(3'd2, 32'h0, "rst_rd_mask");
    rd(3'd3, 32'h0, "rst_rd_cap");
    rd(3'd6, 32'h0, "rst_rd_rise");
    rd(3'd7, 32'h0, "rst_rd_fall");

    // output load / set / clear aliases
    wr(3'd0, 32'h0000_00F0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h10);
    check("out_port_e1", out_port, 32'hE1);
    rd(3'd1, 32'hE1, "rd_out_e1");
    rd(3'd4, 32'h0, "rd_set_alias");

    // rising-edge latency: capture and irq only after edge N+6
    wr(3'd6, 32'h1);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      cyc(1);
      check($sformatf("lat_irq_%0d", k), {31'h0, irq}, (k >= 6) ? 32'h1 : 32'h0);
    end
    rd(3'd3, 32'h1, "lat_cap");
    rd(3'd0, 32'h1, "lat_data");
    wr(3'd3, 32'h1);
    check("irq_after_clr", {31'h0, irq}, 32'h0);
    rd(3'd3, 32'h0, "cap_after_clr");

    // 3-cycle glitch on bit 3 is filtered
    wr(3'd6, 32'h9);
    wr(3'd7, 32'h8);
    in_port[3] = 1'b1;
    cyc(3);
    in_port[3] = 1'b0;
    cyc(10);
    rd(3'd3, 32'h0, "glitch_cap");
    rd(3'd0, 32'h1, "glitch_data");
    check("glitch_irq", {31'h0, irq}, 32'h0);

    // fall-only enable on bit 2
    wr(3'd6, 32'h1);
    wr(3'd7, 32'h4);
    in_port[2] = 1'b1;
    cyc(10);
    rd(3'd3, 32'h0, "fall_rise_ignored");
    rd(3'd0, 32'h5, "fall_data_hi");
    in_port[2] = 1'b0;
    cyc(10);
    rd(3'd3, 32'h4, "fall_cap");
    check("fall_irq_masked", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h4, "fall_clr_zero");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "fall_clr_bit");

    // new edge and clear on bit 1 land on the same clock edge
    wr(3'd6, 32'h2);
    in_port[1] = 1'b1;
    cyc(6);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h2, "set_beats_clr");
    wr(3'd6, 32'h0);
    rd(3'd3, 32'h2, "rise_en_keeps_cap");
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, "cap_clr_bit1");

    // asynchronous reset in the middle of a debounce
    in_port[4] = 1'b1;
    cyc(3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", out_port, 32'hA5);
    check("async_rst_rdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd0, 32'h0, "post_rst_stable");
    cyc(10);
    rd(3'd0, 32'h13, "post_rst_data");
    rd(3'd3, 32'h0, "post_rst_cap");
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    rd(3'd6, 32'h0, "post_rst_rise");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
